// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array feeder.
package systolic_pkg;

    localparam int N          = 3;
    localparam int FEED_STEPS = 2 * N - 1;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and stream bundle between a controller (master) and the feeder (slave).
interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int DW = DEFAULT_DW
);
    logic            start;
    logic [9*DW-1:0] a_mat;
    logic [9*DW-1:0] b_mat;
    logic            busy;
    logic            done;
    logic            acc_clr;
    logic [DW-1:0]   a1, a2, a3;
    logic [DW-1:0]   b1, b2, b3;

    modport master (
        output start, a_mat, b_mat,
        input  busy, done, acc_clr, a1, a2, a3, b1, b2, b3
    );

    modport slave (
        input  start, a_mat, b_mat,
        output busy, done, acc_clr, a1, a2, a3, b1, b2, b3
    );
endinterface

// File: rtl/systolic_skew_sel.sv
// Picks the element a lane presents at feed step t, or zero outside the
// diagonal window. IS_B=0 walks a row of A, IS_B=1 walks a column of B.
module systolic_skew_sel
    import systolic_pkg::*;
#(
    parameter int DW   = DEFAULT_DW,
    parameter bit IS_B = 1'b0
) (
    input  logic [1:0]      lane,
    input  logic [2:0]      t,
    input  logic [9*DW-1:0] mat,
    output logic [DW-1:0]   value
);
    logic [DW-1:0] cells [9];
    int            diff;
    logic [3:0]    idx;

    // Unpack the row-major matrix into addressable cells.
    always_comb begin
        for (int e = 0; e < 9; e++) begin
            cells[e] = mat[e*DW +: DW];
        end
    end

    // Lane l starts l steps late; outside its 3-step window it emits zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        value = '0;
        idx   = '0;
        diff  = int'(t) - int'(lane);
        if (diff >= 0 && diff < N) begin
            idx   = IS_B ? 4'(N * diff + int'(lane)) : 4'(N * int'(lane) + diff);
            value = cells[idx];
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// Captures A and B on start, optionally pulses acc_clr, streams the skewed
// rows/columns into a 3x3 systolic array, drains, then pulses done.
// Build option: define SYSTOLIC_FEEDER_CLR_EN to include the CLR state and acc_clr pulse.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DRAIN = 3
) (
    input  logic             clk,
    input  logic             reset,
    systolic_feeder_if.slave bus
);
    localparam logic [2:0] T_LAST     = 3'(FEED_STEPS - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

`ifdef SYSTOLIC_FEEDER_CLR_EN
    localparam state_t FIRST_STATE = ST_CLR;
`else
    localparam state_t FIRST_STATE = ST_FEED;
`endif

    state_t          state_q, state_d;
    logic [2:0]      t_q, t_d;
    logic [3:0]      drain_q, drain_d;
    logic [9*DW-1:0] a_cap_q, a_cap_d;
    logic [9*DW-1:0] b_cap_q, b_cap_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  acc_clr_q, acc_clr_d;
    logic [N-1:0][DW-1:0]  a_q, a_d, a_sel;
    logic [N-1:0][DW-1:0]  b_q, b_d, b_sel;

    // Next-state, step/drain counters and operand capture.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        drain_d = drain_q;
        a_cap_d = a_cap_q;
        b_cap_d = b_cap_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = FIRST_STATE;
                    t_d     = '0;
                    a_cap_d = bus.a_mat;
                    b_cap_d = bus.b_mat;
                end
            end
            ST_CLR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = ST_DRAIN;
                    t_d     = '0;
                    drain_d = '0;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One selector per lane, fed with next-cycle step and matrix so the
    // stream registers hold the element for the step being entered.
    for (genvar g = 0; g < N; g++) begin : g_lane
        systolic_skew_sel #(.DW(DW), .IS_B(1'b0)) u_sel_a (
            .lane  (2'(g)),
            .t     (t_d),
            .mat   (a_cap_d),
            .value (a_sel[g])
        );
        systolic_skew_sel #(.DW(DW), .IS_B(1'b1)) u_sel_b (
            .lane  (2'(g)),
            .t     (t_d),
            .mat   (b_cap_d),
            .value (b_sel[g])
        );
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
`ifdef SYSTOLIC_FEEDER_CLR_EN
        acc_clr_d = (state_d == ST_CLR);
`else
        acc_clr_d = 1'b0;
`endif
        a_d = (state_d == ST_FEED) ? a_sel : '0;
        b_d = (state_d == ST_FEED) ? b_sel : '0;
    end

    // State, counters, captured operands and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the capture registers are reset too, so no stale operand survives an aborted run.
            state_q   <= ST_IDLE;
            t_q       <= '0;
            drain_q   <= '0;
            a_cap_q   <= '0;
            b_cap_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            t_q       <= t_d;
            drain_q   <= drain_d;
            a_cap_q   <= a_cap_d;
            b_cap_q   <= b_cap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_clr_q <= acc_clr_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.acc_clr = acc_clr_q;
    assign bus.a1      = a_q[0];
    assign bus.a2      = a_q[1];
    assign bus.a3      = a_q[2];
    assign bus.b1      = b_q[0];
    assign bus.b2      = b_q[1];
    assign bus.b3      = b_q[2];
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: the driver pushes the expected
// per-cycle outputs from a matrix-level model; a monitor pops and compares.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int DW = 8;
    localparam int DR = 3;
`ifdef SYSTOLIC_FEEDER_CLR_EN
    localparam int CLR_CYC = 1;
`else
    localparam int CLR_CYC = 0;
`endif
    localparam int RUN_LEN = CLR_CYC + 5 + DR + 1;

    typedef logic [DW-1:0] elem_t;
    typedef struct packed {
        logic             busy;
        logic             done;
        logic             acc_clr;
        logic [2:0][DW-1:0] a;
        logic [2:0][DW-1:0] b;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    systolic_feeder_if #(.DW(DW)) bus ();

    systolic_feeder #(.DW(DW), .DRAIN(DR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    obs_t  pending[$];
    bit    cur_busy;
    int    n_vec  = 0;
    int    n_miss = 0;
    elem_t da [3][3];
    elem_t db [3][3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack_mat(input elem_t m [3][3]);
        logic [9*DW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(3*r+c)*DW +: DW] = m[r][c];
        return v;
    endfunction

    // Expected trace of one run, straight from the skew rule.
    function automatic void model_run(input elem_t ma [3][3], input elem_t mb [3][3]);
        obs_t rec;
        int   t, k;
        for (int c = 0; c < RUN_LEN; c++) begin
            rec      = '0;
            rec.busy = 1'b1;
            if (c < CLR_CYC) begin
                rec.acc_clr = 1'b1;
            end else if (c < CLR_CYC + 5) begin
                t = c - CLR_CYC;
                for (int i = 0; i < 3; i++) begin
                    k = t - i;
                    if (k >= 0 && k <= 2) begin
                        rec.a[i] = ma[i][k];
                        rec.b[i] = mb[k][i];
                    end
                end
            end else if (c == RUN_LEN - 1) begin
                rec.done = 1'b1;
            end
            pending.push_back(rec);
        end
    endfunction

    task automatic rand_mats();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                da[r][c] = elem_t'($urandom);
                db[r][c] = elem_t'($urandom);
            end
    endtask

    // One cycle: drive inputs for the coming edge and queue the expected
    // outputs for the cycle after it.
    task automatic step(input bit s);
        obs_t rec;
        bus.start = s;
        bus.a_mat = pack_mat(da);
        bus.b_mat = pack_mat(db);
        if (reset === 1'b1 && s && !cur_busy)
            model_run(da, db);
        rec      = (pending.size() > 0) ? pending.pop_front() : obs_t'('0);
        cur_busy = rec.busy;
        exp_q.push_back(rec);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: everything is expected to read zero this cycle.
    task automatic reset_assert();
        reset     = 1'b0;
        bus.start = 1'b0;
        exp_q.delete();
        pending.delete();
        cur_busy = 1'b0;
        exp_q.push_back(obs_t'('0));
    endtask

    // Monitor: compare each sampled cycle against the scoreboard.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy",    32'(bus.busy),    32'(e.busy));
                check("done",    32'(bus.done),    32'(e.done));
                check("acc_clr", 32'(bus.acc_clr), 32'(e.acc_clr));
                check("a1", 32'(bus.a1), 32'(e.a[0]));
                check("a2", 32'(bus.a2), 32'(e.a[1]));
                check("a3", 32'(bus.a3), 32'(e.a[2]));
                check("b1", 32'(bus.b1), 32'(e.b[0]));
                check("b2", 32'(bus.b2), 32'(e.b[1]));
                check("b3", 32'(bus.b3), 32'(e.b[2]));
            end
        end
    end

    // Driver.
    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a_mat = '0;
        bus.b_mat = '0;
        cur_busy  = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                da[r][c] = '0;
                db[r][c] = '0;
            end
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        reset_assert();
        repeat (2) step(1'b0);
        reset = 1'b1;

        // Basic feed with the reference matrices.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                da[r][c] = elem_t'(3*r + c + 1);
        db[0][0] = 8'd2; db[1][0] = 8'd4; db[2][0] = 8'd6;
        db[0][1] = 8'd1; db[1][1] = 8'd5; db[2][1] = 8'd9;
        db[0][2] = 8'd3; db[1][2] = 8'd7; db[2][2] = 8'd8;
        step(1'b1);
        repeat (RUN_LEN + 2) step(1'b0);

        // Start while busy and operand changes after capture are ignored.
        rand_mats();
        step(1'b1);
        repeat (3) begin rand_mats(); step(1'b0); end
        rand_mats();
        step(1'b1);
        repeat (RUN_LEN + 2) begin rand_mats(); step(1'b0); end

        // Reset during feed step t=2, then a clean run.
        rand_mats();
        step(1'b1);
        repeat (2 + CLR_CYC) step(1'b0);
        reset_assert();
        step(1'b1);
        step(1'b0);
        reset = 1'b1;
        step(1'b0);
        rand_mats();
        step(1'b1);
        repeat (RUN_LEN + 2) step(1'b0);

        // start held high: back-to-back runs.
        repeat (3 * (RUN_LEN + 1)) begin rand_mats(); step(1'b1); end
        repeat (RUN_LEN + 2) step(1'b0);

        // All-ones elements.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                da[r][c] = 8'hFF;
                db[r][c] = 8'hFF;
            end
        step(1'b1);
        repeat (RUN_LEN + 2) step(1'b0);

        // Random traffic.
        repeat (300) begin
            rand_mats();
            step($urandom_range(0, 3) == 0);
        end
        repeat (RUN_LEN + 2) step(1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream input stage for the 3x3 `Systolic_array`. It captures two 3x3 operand matrices A and B on a start handshake and pulses an accumulator clear. It then drives the skewed row streams (`a1..a3`) and column streams (`b1..b3`) that the array expects, waits a fixed drain interval, and signals completion. Its outputs connect directly to the array's `a*`/`b*` inputs; `acc_clr` drives the array's active-high clear.

## Interface
- `DW`, default 8: element width; must match the array's input width.
- `DRAIN`, default 3: idle cycles after the last feed step before `done`; range 1..15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `start` in 1: request a new computation; accepted only in IDLE.
- `a_mat` in 9*DW: A row-major; A[i][k] at bits [(3i+k)*DW +: DW].
- `b_mat` in 9*DW: B row-major; B[k][j] at bits [(3k+j)*DW +: DW].
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `acc_clr` out 1: one-cycle clear pulse to the array.
- `a1`, `a2`, `a3` out DW: row streams into array rows 1..3.
- `b1`, `b2`, `b3` out DW: column streams into array columns 1..3.

## Operation
- FSM states and transitions:
  - IDLE → CLR when `start`=1. At that edge, `a_mat`/`b_mat` are captured into internal registers.
  - CLR → FEED after 1 cycle.
  - FEED → DRAIN after 5 cycles; step counter t runs 0..4.
  - DRAIN → DONE after DRAIN cycles.
  - DONE → IDLE after 1 cycle.
- Skew rule at feed step t, for i, j in 1..3:
  - `a_i` = A[i-1][t-(i-1)] when 0 ≤ t-(i-1) ≤ 2, else 0.
  - `b_j` = B[t-(j-1)][j-1] when 0 ≤ t-(j-1) ≤ 2, else 0.
- All stream outputs are 0 outside FEED.
- Values pass through unchanged; there is no arithmetic and no width change.
- Boundary conditions:
  - `start` while `busy` is ignored, with no effect on captured data.
  - Changes on `a_mat`/`b_mat` after capture are ignored.
  - `start` held high through DONE begins a new run on the cycle after returning to IDLE.
- Reset (including mid-operation) forces the following immediately; the next run requires a new `start`:
  - state IDLE and t=0;
  - captured matrices cleared;
  - all outputs 0.

## Timing
- All outputs are registered.
- For `start` sampled high at edge k:
  - `busy` goes high from cycle k+1.
  - `acc_clr` is high during cycle k+1.
  - Feed steps t=0..4 are presented during cycles k+2..k+6.
  - DRAIN occupies cycles k+7..k+6+DRAIN.
  - `done` is high during cycle k+7+DRAIN.
  - IDLE (`busy`=0) is reached at cycle k+8+DRAIN.
- Minimum start-to-start spacing is 8+DRAIN cycles.
- Reset values: `busy`=0, `done`=0, `acc_clr`=0, `a1..a3`=0, `b1..b3`=0.

## Configuration
- `SYSTOLIC_FEEDER_CLR_EN` defined: the CLR state exists and `acc_clr` pulses as described above.
- `SYSTOLIC_FEEDER_CLR_EN` undefined:
  - The CLR state is removed, so IDLE → FEED directly.
  - Feed steps occupy cycles k+1..k+5 and `done` moves to cycle k+6+DRAIN.
  - `acc_clr` is tied to 0; the integration clears the array externally.

## Structure
- Package `systolic_pkg` holds:
  - constant N=3;
  - FEED_STEPS = 2N-1 = 5;
  - the FSM state enum (IDLE, CLR, FEED, DRAIN, DONE);
  - the default DW.
- One sub-module, `systolic_skew_sel`: combinational. It maps (lane index, step t, captured matrix) to an element or zero, and is instantiated once per A lane and once per B lane.
- The feeder top holds the FSM, the step/drain counters, the capture registers and the output registers.

## Test plan
- Basic feed: A = [[1,2,3],[4,5,6],[7,8,9]], B columns (2,4,6), (1,5,9), (3,7,8), then `start` → expect, for steps t=0..4:
  - `a1`: 1,2,3,0,0
  - `a2`: 0,4,5,6,0
  - `a3`: 0,0,7,8,9
  - `b1`: 2,4,6,0,0
  - `b2`: 0,1,5,9,0
  - `b3`: 0,0,3,7,8
  - The same vector applied to `Systolic_array` through the feeder → C = A·B.
- Handshake timing: `start` pulse at edge k with DRAIN=3 → `acc_clr` high at k+1, `done` high only at k+10, `busy` low at k+11.
- Busy rejection: a second `start` with different matrices at k+4 → stream unchanged from the first run; no second `done` pulse.
- Mid-run reset: assert `reset`=0 during feed step t=2 → all outputs 0 within the same cycle and IDLE; a later `start` runs a complete, correct sequence.
- Back-to-back: `start` held high continuously → consecutive runs spaced exactly 8+DRAIN cycles apart, each preceded by its own `acc_clr` pulse.
- Max values: all elements 8'hFF, DW=8 → every nonzero stream slot equals 8'hFF and all zero slots are exactly 0.
